// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one 4x4 array multiplier among NREQ requesters.
// Optional macro MULT_ARB_PIPE_EN inserts an extra product register (CALC2 state) for timing.

// One-bit full adder cell of the array multiplier.
module array_mult_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// Four-bit ripple adder row; s_o[4] is the carry out.
module array_mult_add4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [4:0] s_o
);
    logic c1, c2, c3;
    array_mult_fa u_f0 (.a_i(a_i[0]), .b_i(b_i[0]), .c_i(1'b0), .s_o(s_o[0]), .c_o(c1));
    array_mult_fa u_f1 (.a_i(a_i[1]), .b_i(b_i[1]), .c_i(c1),   .s_o(s_o[1]), .c_o(c2));
    array_mult_fa u_f2 (.a_i(a_i[2]), .b_i(b_i[2]), .c_i(c2),   .s_o(s_o[2]), .c_o(c3));
    array_mult_fa u_f3 (.a_i(a_i[3]), .b_i(b_i[3]), .c_i(c3),   .s_o(s_o[3]), .c_o(s_o[4]));
endmodule

// Combinational unsigned 4x4 array multiplier: AND partial products summed by three adder rows.
module array_mult_structural (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [3:0] pp0, pp1, pp2, pp3;
    logic [4:0] s1, s2, s3;
    assign pp0 = a_i & {4{b_i[0]}};
    assign pp1 = a_i & {4{b_i[1]}};
    assign pp2 = a_i & {4{b_i[2]}};
    assign pp3 = a_i & {4{b_i[3]}};
    array_mult_add4 u_r1 (.a_i({1'b0, pp0[3:1]}), .b_i(pp1), .s_o(s1));
    array_mult_add4 u_r2 (.a_i(s1[4:1]),          .b_i(pp2), .s_o(s2));
    array_mult_add4 u_r3 (.a_i(s2[4:1]),          .b_i(pp3), .s_o(s3));
    assign p_o = {s3, s2[0], s1[0], pp0[0]};
endmodule

// Arbiter, operand/product registers and response channel around the shared multiplier.
module mult_share_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_m,
    input  logic [4*NREQ-1:0] req_q,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_p,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);
`ifdef MULT_ARB_PIPE_EN
    typedef enum logic [1:0] {IDLE, CALC, CALC2, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`endif

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [3:0]     op_m_q, op_m_d, op_q_q, op_q_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic [7:0]     rsp_p_q, rsp_p_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;
`ifdef MULT_ARB_PIPE_EN
    logic [7:0]     pipe_p_q, pipe_p_d;
`endif
    logic [7:0]     mult_p;
    logic [IDW-1:0] win_idx, ptr_nxt;
    logic           win_found;
    logic [IDW:0]   cand, nxt;

    array_mult_structural u_mult (.a_i(op_m_q), .b_i(op_q_q), .p_o(mult_p));

    // Round-robin search: the lowest offset from ptr with a valid request wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
        nxt       = {1'b0, win_idx} + (IDW+1)'(1);
        ptr_nxt   = (nxt == (IDW+1)'(NREQ)) ? '0 : nxt[IDW-1:0];
        req_ready = (rst_n && state_q == IDLE && win_found) ? (NREQ'(1) << win_idx) : '0;
    end

    // Next-state and datapath-load decisions of the sharing FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_m_d      = op_m_q;
        op_q_d      = op_q_q;
        op_id_d     = op_id_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
`ifdef MULT_ARB_PIPE_EN
        pipe_p_d    = pipe_p_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_m_d  = req_m[int'(win_idx)*4 +: 4];
                    op_q_d  = req_q[int'(win_idx)*4 +: 4];
                    op_id_d = win_idx;
                    ptr_d   = ptr_nxt;
                    state_d = CALC;
                end
            end
`ifdef MULT_ARB_PIPE_EN
            CALC: begin
                pipe_p_d = mult_p;
                state_d  = CALC2;
            end
            CALC2: begin
                rsp_p_d     = pipe_p_q;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
`else
            CALC: begin
                rsp_p_d     = mult_p;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_m_q      <= '0;
            op_q_q      <= '0;
            op_id_q     <= '0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifdef MULT_ARB_PIPE_EN
            pipe_p_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_m_q      <= op_m_d;
            op_q_q      <= op_q_d;
            op_id_q     <= op_id_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef MULT_ARB_PIPE_EN
            pipe_p_q    <= pipe_p_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed and randomized checks of mult_share_arb against a transaction-level model.
module tb_mult_share_arb;
    localparam int NREQ = 4;
`ifdef MULT_ARB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_m, req_q;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid, rsp_ready;
    logic [7:0]        rsp_p;
    logic [1:0]        rsp_id;
    logic              busy;
    int                checks = 0;
    int                failures = 0;

    mult_share_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_m(req_m), .req_q(req_q),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case any loop fails to terminate.
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_m = '0;
        req_q = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_m = 16'hFFFF;
        req_q = 16'hFFFF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
            checks++; if (rsp_p !== 8'h00) begin failures++; $display("FAIL reset_rsp_p got=%h exp=00", rsp_p); end
            checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_m[11:8] = 4'd6;
        req_q[11:8] = 4'd15;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c < LAT) begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0 at cycle %0d", rsp_valid, c); end
            end else begin
                checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
                checks++; if (rsp_p !== 8'h5A) begin failures++; $display("FAIL single_p got=%h exp=5a", rsp_p); end
                checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_rotate();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int exp_p[5]  = '{1, 105, 50, 225, 1};
        int got = 0;
        do_reset();
        req_valid = 4'b1111;
        req_m = {4'd15, 4'd5, 4'd7, 4'd1};
        req_q = {4'd15, 4'd10, 4'd15, 4'd1};
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                checks++; if (int'(rsp_id) != exp_id[got]) begin failures++; $display("FAIL rotate_id[%0d] got=%0d exp=%0d", got, rsp_id, exp_id[got]); end
                checks++; if (int'(rsp_p) != exp_p[got]) begin failures++; $display("FAIL rotate_p[%0d] got=%0d exp=%0d", got, rsp_p, exp_p[got]); end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 5) begin failures++; $display("FAIL rotate_count got=%0d exp=5", got); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0001;
        req_m[3:0] = 4'd9;
        req_q[3:0] = 4'd7;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant got=%b exp=0001", req_ready); end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            req_valid = 4'b1110;
            req_m[15:4] = 12'h321;
            req_q[15:4] = 12'h456;
        end
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            req_valid[3] = (h < 2);
            req_m[3:0] = 4'(h);
            #1;
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", h, rsp_valid); end
            checks++; if (rsp_p !== 8'd63) begin failures++; $display("FAIL bp_p[%0d] got=%0d exp=63", h, rsp_p); end
            checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL bp_id[%0d] got=%0d exp=0", h, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", h, req_ready); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy[%0d] got=%b exp=1", h, busy); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_after_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_after_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100;
        req_m[11:8] = 4'd3;
        req_q[11:8] = 4'd3;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_grant got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_calc_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_rsp[%0d] got=%b exp=0", c, rsp_valid); end
            @(negedge clk);
            #1;
        end
        req_valid = 4'b1111;
        req_m = {4'd2, 4'd2, 4'd2, 4'd11};
        req_q = {4'd2, 4'd2, 4'd2, 4'd13};
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr_grant got=%b exp=0001", req_ready); end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            req_valid = '0;
        end
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_resume_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_p !== 8'd143) begin failures++; $display("FAIL mid_resume_p got=%0d exp=143", rsp_p); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL mid_resume_id got=%0d exp=0", rsp_id); end
    endtask

    task automatic test_random();
        int m_ptr = 0;
        bit m_idle = 1'b1;
        int m_cnt = 0;
        int q_id[$];
        int q_p[$];
        int pair = 0;
        int done = 0;
        int cyc = 0;
        int last_g = -1;
        int g;
        int wait_g[NREQ];
        int pp[NREQ];
        bit exp_rv;
        logic [NREQ-1:0] exp_ready;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin wait_g[i] = 0; pp[i] = 0; end
        while (done < 300 && cyc < 20000) begin
            if (last_g >= 0) begin req_valid[last_g] = 1'b0; last_g = -1; end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    pp[i] = pair % 256;
                    pair++;
                    req_m[4*i +: 4] = 4'(pp[i] / 16);
                    req_q[4*i +: 4] = 4'(pp[i] % 16);
                    req_valid[i] = 1'b1;
                    wait_g[i] = 0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!m_idle && m_cnt > 0) m_cnt--;
            exp_rv = !m_idle && m_cnt == 0;
            checks++; if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
            if (rsp_valid === 1'b1 && exp_rv) begin
                checks++;
                if (q_id.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected cyc=%0d got=%0d exp=none", cyc, rsp_p);
                end else if (int'(rsp_id) != q_id[0] || int'(rsp_p) != q_p[0]) begin
                    failures++; $display("FAIL rand_rsp cyc=%0d got=id%0d/%0d exp=id%0d/%0d", cyc, rsp_id, rsp_p, q_id[0], q_p[0]);
                end
            end
            g = -1;
            if (m_idle)
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            checks++; if (busy !== !m_idle) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, !m_idle); end
            if (g >= 0) begin
                q_id.push_back(g);
                q_p.push_back((pp[g] / 16) * (pp[g] % 16));
                checks++; if (wait_g[g] >= NREQ) begin failures++; $display("FAIL rand_starve id=%0d got=%0d exp<%0d", g, wait_g[g], NREQ); end
                for (int i = 0; i < NREQ; i++) if (i != g && req_valid[i]) wait_g[i]++;
                wait_g[g] = 0;
                m_ptr = (g + 1) % NREQ;
                m_idle = 1'b0;
                m_cnt = LAT;
                last_g = g;
            end else if (exp_rv && rsp_ready) begin
                if (q_id.size() > 0) begin void'(q_id.pop_front()); void'(q_p.pop_front()); end
                done++;
                m_idle = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (done < 300) begin failures++; $display("FAIL rand_timeout got=%0d exp=300", done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
